// File: rtl/gf_mix_column_seq_if.sv
// Valid/ready bus of the iterative GF(2^8) column mixer: input column with
// matrix select on one side, completed result column on the other.
interface gf_mix_column_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_col;
  logic [1:0]  in_mode;
  logic [31:0] in_coef;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_col;
  logic        busy;

  modport master (
    output in_valid, in_col, in_mode, in_coef, out_ready,
    input  in_ready, out_valid, out_col, busy
  );

  modport slave (
    input  in_valid, in_col, in_mode, in_coef, out_ready,
    output in_ready, out_valid, out_col, busy
  );
endinterface

// File: rtl/gf_mix_column_seq.sv
// Iterative GF(2^8) circulant-matrix x 4-byte column product, LANES output
// bytes per cycle, with forward/inverse/custom first rows.
module gf_mix_column_seq #(
  parameter int          LANES = 1,
  parameter logic [7:0]  POLY  = 8'h1B
) (
  input  logic               clk,
  input  logic               rst_n,
  gf_mix_column_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [31:0] ROW_FWD = 32'h02030101;
  localparam logic [31:0] ROW_INV = 32'h0e0b0d09;

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("gf_mix_column_seq: LANES must be 1, 2 or 4");
  end

  // Carry-less multiply with reduction after every shift of the multiplicand.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (x & {8{b[i]}});
      x = {x[6:0], 1'b0} ^ (POLY & {8{x[7]}});
    end
    return p;
  endfunction

  // Output byte i: row i of the circulant is the first row rotated right by i bytes.
  function automatic logic [7:0] row_dot(input logic [31:0] col, input logic [31:0] row,
                                         input logic [1:0] i);
    logic [7:0] acc;
    logic [1:0] k;
    acc = 8'h00;
    for (int c = 0; c < 4; c++) begin
      k   = 2'(c) - i;
      acc = acc ^ gmul(row[8*(3-k) +: 8], col[8*(3-c) +: 8]);
    end
    return acc;
  endfunction

  logic [1:0]  state_r;
  logic [1:0]  idx_r;
  logic [31:0] col_r;
  logic [31:0] row_r;
  logic [31:0] res_r;
  logic [31:0] out_col_r;

  logic [31:0] row_sel_s;
  logic [31:0] res_next_s;
  logic [1:0]  row_s;
  logic [2:0]  idx_sum_s;
  logic        last_s;
  logic        in_ready_s;
  logic        accept_s;

  // Resolve the first matrix row from the mode; reserved mode falls back to forward.
  always_comb begin
    row_sel_s = ROW_FWD;
    case (bus.in_mode)
      2'd0:    row_sel_s = ROW_FWD;
      2'd1:    row_sel_s = ROW_INV;
      2'd2:    row_sel_s = bus.in_coef;
      default: row_sel_s = ROW_FWD;
    endcase
  end

  // Input is taken while idle, or in DONE exactly when the result is being taken.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: in_ready_s = 1'b1;
      ST_DONE: in_ready_s = bus.out_ready;
      default: in_ready_s = 1'b0;
    endcase
  end

  assign accept_s  = bus.in_valid & in_ready_s;
  assign idx_sum_s = {1'b0, idx_r} + 3'(LANES);
  assign last_s    = (idx_sum_s == 3'd4);

  // Merge this cycle's LANES rows into the partial result.
  always_comb begin
    res_next_s = res_r;
    row_s      = 2'd0;
    for (int l = 0; l < LANES; l++) begin
      row_s = idx_r + 2'(l);
      res_next_s[8*(3-row_s) +: 8] = row_dot(col_r, row_r, row_s);
    end
  end

  // Control FSM, operand capture and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      idx_r     <= 2'd0;
      col_r     <= 32'h0;
      row_r     <= 32'h0;
      res_r     <= 32'h0;
      out_col_r <= 32'h0;
    end else if (accept_s) begin
      col_r   <= bus.in_col;
      row_r   <= row_sel_s;
      idx_r   <= 2'd0;
      state_r <= ST_BUSY;
    end else begin
      case (state_r)
        ST_IDLE: state_r <= ST_IDLE;
        ST_BUSY: begin
          res_r <= res_next_s;
          if (last_s) begin
            out_col_r <= res_next_s;
            state_r   <= ST_DONE;
          end else begin
            idx_r <= idx_sum_s[1:0];
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == ST_DONE);
  assign bus.busy      = (state_r == ST_BUSY);
  assign bus.out_col   = out_col_r;

endmodule

// File: tb/tb_gf_mix_column_seq.sv
// Scoreboard bench for gf_mix_column_seq: one instance each for LANES 1, 2, 4,
// directed columns with hand-computed MixColumns results.
module tb_gf_mix_column_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]       in_valid;
  logic [2:0]       out_ready;
  logic [2:0][31:0] in_col;
  logic [2:0][31:0] in_coef;
  logic [2:0][1:0]  in_mode;
  wire  [2:0]       in_ready;
  wire  [2:0]       out_valid;
  wire  [2:0]       busy;
  wire  [2:0][31:0] out_col;

  // index 0: LANES=1, index 1: LANES=2, index 2: LANES=4
  for (genvar g = 0; g < 3; g++) begin : g_dut
    gf_mix_column_seq_if bus ();
    assign bus.in_valid  = in_valid[g];
    assign bus.in_col    = in_col[g];
    assign bus.in_mode   = in_mode[g];
    assign bus.in_coef   = in_coef[g];
    assign bus.out_ready = out_ready[g];
    assign in_ready[g]   = bus.in_ready;
    assign out_valid[g]  = bus.out_valid;
    assign out_col[g]    = bus.out_col;
    assign busy[g]       = bus.busy;
    gf_mix_column_seq #(.LANES(1 << g), .POLY(8'h1B)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q [3][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // Issue one column once the DUT is ready; the expected result goes to the scoreboard.
  task automatic start(input int d, input logic [31:0] col, input logic [1:0] mode,
                       input logic [31:0] coef, input logic [31:0] want);
    int n = 0;
    while (!in_ready[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("accept_ready_dut%0d", d), 32'(in_ready[d]), 32'd1);
    in_valid[d] = 1'b1;
    in_col[d]   = col;
    in_mode[d]  = mode;
    in_coef[d]  = coef;
    exp_q[d].push_back(want);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  // Count cycles from the accept edge to out_valid; the block must look busy meanwhile.
  task automatic wait_result(input int d, input int want_lat, input string name);
    int   lat     = 0;
    logic busy_ok = 1'b1;
    while (!out_valid[d] && lat < 20) begin
      if (in_ready[d] !== 1'b0 || busy[d] !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(want_lat));
    check({name, "_busy_window"}, 32'(busy_ok), 32'd1);
  endtask

  // Monitor: a result is consumed on the coming edge whenever valid and ready are both high.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst_n && out_valid[d] && out_ready[d]) begin
        if (exp_q[d].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result dut%0d: got %h, none expected", d, out_col[d]);
        end else begin
          check($sformatf("result_dut%0d", d), out_col[d], exp_q[d].pop_front());
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '1;
    in_col    = '0;
    in_coef   = '0;
    in_mode   = '0;
    #12;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_in_ready_dut%0d", d), 32'(in_ready[d]), 32'd1);
      check($sformatf("rst_out_valid_dut%0d", d), 32'(out_valid[d]), 32'd0);
      check($sformatf("rst_out_col_dut%0d", d), out_col[d], 32'h0);
      check($sformatf("rst_busy_dut%0d", d), 32'(busy[d]), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // forward, LANES=1
    start(0, 32'hdb135345, 2'd0, 32'h0, 32'h8e4da1bc);
    wait_result(0, 4, "fwd_l1");

    // inverse, LANES=4, back to back
    start(2, 32'h8e4da1bc, 2'd1, 32'h0, 32'hdb135345);
    wait_result(2, 1, "inv_l4_a");
    start(2, 32'h9fdc589d, 2'd1, 32'h0, 32'hf20a225c);
    wait_result(2, 1, "inv_l4_b");

    // custom rows, LANES=2
    start(1, 32'hdeadbeef, 2'd2, 32'h01000000, 32'hdeadbeef);
    wait_result(1, 2, "ident_l2");
    start(1, 32'hdeadbeef, 2'd2, 32'h00000000, 32'h00000000);
    wait_result(1, 2, "zero_l2");

    // backpressure, then a new column accepted as the held result is taken
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    start(0, 32'hdb135345, 2'd0, 32'h0, 32'h8e4da1bc);
    wait_result(0, 4, "bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_col_hold", out_col[0], 32'h8e4da1bc);
      check("bp_in_ready_low", 32'(in_ready[0]), 32'd0);
      check("bp_out_valid_hold", 32'(out_valid[0]), 32'd1);
    end
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_col[0]    = 32'hf20a225c;
    in_mode[0]   = 2'd0;
    exp_q[0].push_back(32'h9fdc589d);
    #1;
    check("stream_same_cycle_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    check("stream_accepted_busy", 32'(busy[0]), 32'd1);
    wait_result(0, 4, "stream");

    // reset two cycles into BUSY
    @(posedge clk); #1;
    start(0, 32'hdb135345, 2'd0, 32'h0, 32'h8e4da1bc);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid[0]), 32'd0);
    check("midrst_out_col", out_col[0], 32'h0);
    check("midrst_in_ready", 32'(in_ready[0]), 32'd1);
    check("midrst_busy", 32'(busy[0]), 32'd0);
    exp_q[0].delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start(0, 32'hdb135345, 2'd0, 32'h0, 32'h8e4da1bc);
    wait_result(0, 4, "after_reset");

    // reserved mode, with inputs disturbed after capture
    @(posedge clk); #1;
    start(0, 32'hdb135345, 2'd3, 32'h12345678, 32'h8e4da1bc);
    in_col[0]  = 32'hffffffff;
    in_mode[0] = 2'd1;
    in_coef[0] = 32'h00000000;
    wait_result(0, 4, "mode3_hold");

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("queue_drained_dut%0d", d), 32'(exp_q[d].size()), 32'd0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
